mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one downstream datapath between two requesters (A, B).

---
 rtl/mux_rr_if.sv | 25 ++
 rtl/mux_rr_arbiter.sv | 79 +++++++
 tb/tb_mux_rr_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_if.sv
// mux_rr_if: requester, downstream and status signals of the two-way round-robin arbiter
interface mux_rr_if #(parameter int DATA_W = 8);
  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_last;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_last;
  logic              b_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              sel;
  logic              busy;
  modport slave (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_last, sel, busy
  );
  modport master (
    output a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_last, sel, busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: block-locked round-robin arbiter for two requesters feeding a one-entry output register
module mux_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter bit LOCK_LAST = 1'b1
) (
  input logic     clk,
  input logic     rst,
  mux_rr_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_A = 2'd1;
  localparam logic [1:0] GRANT_B = 2'd2;
  logic [1:0]        state_q, state_d;
  logic              sel_q, sel_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              space, xfer_a, xfer_b, fin_a, fin_b;
  assign space         = !out_valid_q || bus.out_ready;
  assign bus.a_ready   = (state_q == GRANT_A) && space;
  assign bus.b_ready   = (state_q == GRANT_B) && space;
  assign xfer_a        = bus.a_valid && bus.a_ready;
  assign xfer_b        = bus.b_valid && bus.b_ready;
  assign fin_a         = xfer_a && (!LOCK_LAST || bus.a_last);
  assign fin_b         = xfer_b && (!LOCK_LAST || bus.b_last);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = state_q != IDLE;
  // grant sequencing: pick a requester from IDLE, hand over directly on a final beat when the other is waiting
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE) begin
      if (bus.a_valid && (!bus.b_valid || !rr_ptr_q)) begin
        state_d = GRANT_A;
        sel_d   = 1'b0;
      end else if (bus.b_valid) begin
        state_d = GRANT_B;
        sel_d   = 1'b1;
      end
    end else if (fin_a) begin
      rr_ptr_d = 1'b1;
      state_d  = bus.b_valid ? GRANT_B : IDLE;
      sel_d    = bus.b_valid ? 1'b1 : sel_q;
    end else if (fin_b) begin
      rr_ptr_d = 1'b0;
      state_d  = bus.a_valid ? GRANT_A : IDLE;
      sel_d    = bus.a_valid ? 1'b0 : sel_q;
    end
  end
  // output stage: load on transfer, drain on downstream accept, hold otherwise
  always_comb begin
    out_valid_d = xfer_a || xfer_b || (out_valid_q && !bus.out_ready);
    out_data_d  = xfer_a ? bus.a_data : xfer_b ? bus.b_data : out_data_q;
    out_last_d  = xfer_a ? bus.a_last : xfer_b ? bus.b_last : out_last_q;
  end
  // state registers; reset also discards any buffered beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      rr_ptr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scenarios plus randomized traffic checked against an ownership-level model
module tb_mux_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  mux_rr_if #(.DATA_W(8)) bus ();
  mux_rr_if #(.DATA_W(8)) bus2 ();
  mux_rr_arbiter #(.DATA_W(8), .LOCK_LAST(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  mux_rr_arbiter #(.DATA_W(8), .LOCK_LAST(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  // reference model: owner 0 = nobody, 1 = A, 2 = B; pref_b = B wins next contention
  int         m_own;
  bit         m_pref_b, m_ov, m_ol, m_sel;
  logic [7:0] m_od;
  wire m_space = !m_ov || bus.out_ready;
  wire m_ar    = (m_own == 1) && m_space;
  wire m_br    = (m_own == 2) && m_space;
  always @(posedge clk) begin
    if (rst) begin
      m_own <= 0; m_pref_b <= 1'b0; m_ov <= 1'b0; m_ol <= 1'b0; m_sel <= 1'b0; m_od <= 8'h00;
    end else begin
      if (m_ar && bus.a_valid) begin
        m_od <= bus.a_data; m_ol <= bus.a_last; m_ov <= 1'b1;
        if (bus.a_last) begin
          m_pref_b <= 1'b1;
          m_own    <= bus.b_valid ? 2 : 0;
          if (bus.b_valid) m_sel <= 1'b1;
        end
      end else if (m_br && bus.b_valid) begin
        m_od <= bus.b_data; m_ol <= bus.b_last; m_ov <= 1'b1;
        if (bus.b_last) begin
          m_pref_b <= 1'b0;
          m_own    <= bus.a_valid ? 1 : 0;
          if (bus.a_valid) m_sel <= 1'b0;
        end
      end else if (bus.out_ready) begin
        m_ov <= 1'b0;
      end
      if (m_own == 0) begin
        if (bus.a_valid && (!bus.b_valid || !m_pref_b)) begin
          m_own <= 1; m_sel <= 1'b0;
        end else if (bus.b_valid) begin
          m_own <= 2; m_sel <= 1'b1;
        end
      end
    end
  end
  task automatic idle_inputs();
    bus.a_valid = 0; bus.a_data = 0; bus.a_last = 0;
    bus.b_valid = 0; bus.b_data = 0; bus.b_last = 0;
    bus.out_ready = 1;
    bus2.a_valid = 0; bus2.a_data = 0; bus2.a_last = 0;
    bus2.b_valid = 0; bus2.b_data = 0; bus2.b_last = 0;
    bus2.out_ready = 1;
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  // present one beat and hold it until accepted, bounded by a cycle budget
  task automatic xfer(input bit is_b, input logic [7:0] d, input bit l);
    bit done = 0;
    if (is_b) begin bus.b_valid = 1; bus.b_data = d; bus.b_last = l; end
    else      begin bus.a_valid = 1; bus.a_data = d; bus.a_last = l; end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = is_b ? bus.b_ready : bus.a_ready;
      @(posedge clk);
      #1;
    end
    tests++;
    if (!done) begin fails++; $display("FAIL xfer_timeout req=%0d data=%h never accepted", is_b, d); end
    if (is_b) bus.b_valid = 0; else bus.a_valid = 0;
  endtask
  task automatic test_reset();
    idle_inputs();
    do_reset();
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.sel !== 1'b0) begin fails++; $display("FAIL reset_sel got %b want 0", bus.sel); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b%b want 00", bus.a_ready, bus.b_ready); end
    tests++; if (bus.out_data !== 8'h00 || bus.out_last !== 1'b0) begin fails++; $display("FAIL reset_out got %h/%b want 00/0", bus.out_data, bus.out_last); end
  endtask
  task automatic test_single_block();
    logic [7:0] beats [3];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
    idle_inputs();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      xfer(0, beats[i], i == 2);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== beats[i]) begin
        fails++; $display("FAIL single_beat%0d got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_data, beats[i]);
      end
    end
    tests++; if (bus.busy !== 1'b0 || bus.sel !== 1'b0 || bus.out_last !== 1'b1) begin
      fails++; $display("FAIL single_end got busy=%b sel=%b last=%b want 0 0 1", bus.busy, bus.sel, bus.out_last);
    end
  endtask
  task automatic test_contention();
    idle_inputs();
    do_reset();
    bus.b_valid = 1; bus.b_data = 8'hB1; bus.b_last = 0;
    bus.a_valid = 1; bus.a_data = 8'hA1; bus.a_last = 0;
    @(posedge clk); #1;
    tests++; if (bus.sel !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL contend_first got sel=%b busy=%b want 0 1", bus.sel, bus.busy); end
    xfer(0, 8'hA1, 0);
    xfer(0, 8'hA2, 1);
    tests++; if (bus.sel !== 1'b1 || bus.busy !== 1'b1) begin fails++; $display("FAIL handover got sel=%b busy=%b want 1 1", bus.sel, bus.busy); end
    tests++; if (bus.out_data !== 8'hA2) begin fails++; $display("FAIL handover_data got %h want a2", bus.out_data); end
    xfer(1, 8'hB1, 0);
    tests++; if (bus.out_data !== 8'hB1) begin fails++; $display("FAIL b_beat0 got %h want b1", bus.out_data); end
    xfer(1, 8'hB2, 1);
    tests++; if (bus.busy !== 1'b0 || bus.out_data !== 8'hB2) begin fails++; $display("FAIL b_done got busy=%b d=%h want 0 b2", bus.busy, bus.out_data); end
    bus.a_valid = 1; bus.a_data = 8'hA3; bus.a_last = 1;
    bus.b_valid = 1; bus.b_data = 8'hB3; bus.b_last = 1;
    @(posedge clk); #1;
    tests++; if (bus.sel !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL contend_again got sel=%b busy=%b want 0 1", bus.sel, bus.busy); end
    xfer(0, 8'hA3, 1);
    xfer(1, 8'hB3, 1);
    tests++; if (bus.out_data !== 8'hB3 || bus.busy !== 1'b0) begin fails++; $display("FAIL contend_tail got d=%h busy=%b want b3 0", bus.out_data, bus.busy); end
  endtask
  task automatic test_backpressure();
    idle_inputs();
    do_reset();
    xfer(1, 8'h5A, 0);
    bus.out_ready = 0;
    bus.b_valid = 1; bus.b_data = 8'h5B; bus.b_last = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (bus.b_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) begin
        fails++; $display("FAIL stall%0d got rdy=%b v=%b d=%h want 0 1 5a", i, bus.b_ready, bus.out_valid, bus.out_data);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1;
    @(negedge clk);
    tests++; if (bus.b_ready !== 1'b1) begin fails++; $display("FAIL release_ready got %b want 1", bus.b_ready); end
    @(posedge clk); #1;
    bus.b_valid = 0;
    tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5B) begin fails++; $display("FAIL release_load got v=%b d=%h want 1 5b", bus.out_valid, bus.out_data); end
    @(posedge clk); #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL drain got v=%b want 0", bus.out_valid); end
  endtask
  task automatic test_no_lock();
    idle_inputs();
    do_reset();
    bus2.a_valid = 1; bus2.a_data = 8'hAA;
    bus2.b_valid = 1; bus2.b_data = 8'hBB;
    @(posedge clk); #1;
    tests++; if (bus2.sel !== 1'b0 || bus2.out_valid !== 1'b0) begin fails++; $display("FAIL nolock_start got sel=%b v=%b want 0 0", bus2.sel, bus2.out_valid); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      tests++; if (bus2.out_data !== ((k % 2 == 0) ? 8'hAA : 8'hBB) || bus2.sel !== (k % 2 == 0)) begin
        fails++; $display("FAIL nolock_beat%0d got d=%h sel=%b want d=%h sel=%0d", k, bus2.out_data, bus2.sel, (k % 2 == 0) ? 8'hAA : 8'hBB, k % 2 == 0);
      end
    end
    bus2.a_valid = 0; bus2.b_valid = 0;
  endtask
  task automatic test_reset_mid_block();
    idle_inputs();
    do_reset();
    xfer(0, 8'h60, 1);
    xfer(0, 8'h61, 0);
    bus.out_ready = 0;
    bus.a_valid = 1; bus.a_data = 8'h62; bus.a_last = 1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    bus.a_valid = 0; bus.out_ready = 1;
    tests++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.sel !== 1'b0) begin
      fails++; $display("FAIL midrst got busy=%b v=%b sel=%b want 0 0 0", bus.busy, bus.out_valid, bus.sel);
    end
    bus.a_valid = 1; bus.a_data = 8'h63; bus.a_last = 1;
    bus.b_valid = 1; bus.b_data = 8'h64; bus.b_last = 1;
    @(posedge clk); #1;
    tests++; if (bus.sel !== 1'b0) begin fails++; $display("FAIL midrst_rrptr got sel=%b want 0", bus.sel); end
    xfer(0, 8'h63, 1);
    xfer(1, 8'h64, 1);
  endtask
  task automatic test_random();
    bit acc_a, acc_b;
    idle_inputs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!bus.a_valid || acc_a) begin
        bus.a_valid = $urandom_range(0, 2) != 0; bus.a_data = 8'($urandom); bus.a_last = $urandom_range(0, 2) == 0;
      end
      if (!bus.b_valid || acc_b) begin
        bus.b_valid = $urandom_range(0, 2) != 0; bus.b_data = 8'($urandom); bus.b_last = $urandom_range(0, 2) == 0;
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      acc_a = bus.a_valid && m_ar;
      acc_b = bus.b_valid && m_br;
      tests++;
      if (bus.a_ready !== m_ar || bus.b_ready !== m_br || bus.out_valid !== m_ov || bus.busy !== (m_own != 0) || bus.sel !== m_sel ||
          (m_ov && (bus.out_data !== m_od || bus.out_last !== m_ol))) begin
        fails++;
        $display("FAIL rand_c%0d got ar=%b br=%b v=%b busy=%b sel=%b d=%h l=%b want ar=%b br=%b v=%b busy=%b sel=%b d=%h l=%b",
                 c, bus.a_ready, bus.b_ready, bus.out_valid, bus.busy, bus.sel, bus.out_data, bus.out_last,
                 m_ar, m_br, m_ov, m_own != 0, m_sel, m_od, m_ol);
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    test_reset();
    test_single_block();
    test_contention();
    test_backpressure();
    test_no_lock();
    test_reset_mid_block();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
